// File: rtl/fp_int_acc.sv
// Single-operand accumulate step: aligns a 14-bit unsigned magnitude against a
// 32-bit fixed-point accumulator and adds or subtracts it in three clock edges.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the start edge
// ALIGN | shift the operand with the larger exponent down to the smaller one
// ACCUM | add/subtract aligned operands, register result and exponent
module fp_int_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign_in,
    input  logic [4:0]  exp_min,
    input  logic [31:0] fixed_point_acc,
    input  logic [4:0]  exp_in,
    input  logic [13:0] fixed_point_in,
    output logic [4:0]  exp_out,
    output logic [31:0] fixed_point_out
);

    typedef enum logic [1:0] {IDLE, ALIGN, ACCUM} state_t;

    state_t state, state_nxt;
    logic   capture, load_ops, load_out;

    logic        sign_q;
    logic [4:0]  exp_min_q, exp_in_q, exp_res;
    logic [31:0] acc_q, op_a, op_b;
    logic [13:0] in_q;

    logic        in_ge;
    logic [4:0]  shift;
    logic [31:0] in_ext, a_aln, b_aln, result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        load_ops  = 1'b0;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                load_ops  = 1'b1;
                state_nxt = ACCUM;
            end
            ACCUM: begin
                load_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bits shifted past bit 31 are dropped on purpose; no saturation.
    always_comb begin
        in_ge  = (exp_in_q >= exp_min_q);
        shift  = in_ge ? (exp_in_q - exp_min_q) : (exp_min_q - exp_in_q);
        in_ext = {18'd0, in_q};
        a_aln  = in_ge ? acc_q : (acc_q << shift);
        b_aln  = in_ge ? (in_ext << shift) : in_ext;
        result = sign_q ? (op_a - op_b) : (op_a + op_b);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q          <= 1'b0;
            exp_min_q       <= '0;
            exp_in_q        <= '0;
            acc_q           <= '0;
            in_q            <= '0;
            op_a            <= '0;
            op_b            <= '0;
            exp_res         <= '0;
            exp_out         <= '0;
            fixed_point_out <= '0;
        end else begin
            if (capture) begin
                sign_q    <= sign_in;
                exp_min_q <= exp_min;
                exp_in_q  <= exp_in;
                acc_q     <= fixed_point_acc;
                in_q      <= fixed_point_in;
            end
            if (load_ops) begin
                op_a    <= a_aln;
                op_b    <= b_aln;
                exp_res <= in_ge ? exp_min_q : exp_in_q;
            end
            if (load_out) begin
                exp_out         <= exp_res;
                fixed_point_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_fp_int_acc.sv
// Directed bench for fp_int_acc: a latency-aware reference model checked every
// cycle, plus literal expectations for the worked examples and boundaries.
module tb_fp_int_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sign_in = 1'b0;
    logic [4:0]  exp_min = '0;
    logic [31:0] fixed_point_acc = '0;
    logic [4:0]  exp_in = '0;
    logic [13:0] fixed_point_in = '0;
    logic [4:0]  exp_out;
    logic [31:0] fixed_point_out;

    int checks = 0;
    int errors = 0;

    fp_int_acc dut (
        .clk(clk), .rst(rst), .start(start), .sign_in(sign_in),
        .exp_min(exp_min), .fixed_point_acc(fixed_point_acc),
        .exp_in(exp_in), .fixed_point_in(fixed_point_in),
        .exp_out(exp_out), .fixed_point_out(fixed_point_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Arithmetic reference: scale the larger-exponent operand by 2^d, keep 32 bits.
    function automatic logic [36:0] ref_op(input logic s, input logic [4:0] emin,
                                           input logic [31:0] acc, input logic [4:0] ein,
                                           input logic [13:0] mag);
        logic [63:0] a, b, r;
        logic [4:0]  e;
        int          d;
        if (ein >= emin) begin
            d = int'(ein) - int'(emin);
            a = {32'd0, acc};
            b = {50'd0, mag} * (64'd1 << d);
            e = emin;
        end else begin
            d = int'(emin) - int'(ein);
            a = {32'd0, acc} * (64'd1 << d);
            b = {50'd0, mag};
            e = ein;
        end
        r = s ? (a - b) : (a + b);
        return {e, r[31:0]};
    endfunction

    logic [4:0]  m_exp = '0;
    logic [31:0] m_out = '0;
    logic [36:0] pend = '0;
    int          pend_cnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_exp = '0;
            m_out = '0;
            pend_cnt = 0;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) {m_exp, m_out} = pend;
        end else if (start) begin
            pend = ref_op(sign_in, exp_min, fixed_point_acc, exp_in, fixed_point_in);
            pend_cnt = 2;
        end
    end

    always @(negedge clk) begin
        check("cycle_exp", {59'd0, exp_out}, {59'd0, m_exp});
        check("cycle_out", {32'd0, fixed_point_out}, {32'd0, m_out});
    end

    task automatic set_in(input logic s, input logic [4:0] emin, input logic [31:0] acc,
                          input logic [4:0] ein, input logic [13:0] mag);
        sign_in = s;
        exp_min = emin;
        fixed_point_acc = acc;
        exp_in = ein;
        fixed_point_in = mag;
    endtask

    task automatic run_op(input logic s, input logic [4:0] emin, input logic [31:0] acc,
                          input logic [4:0] ein, input logic [13:0] mag);
        @(negedge clk);
        set_in(s, emin, acc, ein, mag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [4:0] e, input logic [31:0] v);
        check({name, "_exp"}, {59'd0, exp_out}, {59'd0, e});
        check({name, "_out"}, {32'd0, fixed_point_out}, {32'd0, v});
    endtask

    initial begin
        // Pin the reference model to the worked examples.
        check("ref_026", {27'd0, ref_op(1'b0, 5'd16, 32'h1, 5'd15, 14'h21F6)}, {27'd0, 5'd15, 32'h21F8});
        check("ref_028", {27'd0, ref_op(1'b0, 5'd10, 32'd5, 5'd12, 14'd3)}, {27'd0, 5'd10, 32'd17});
        check("ref_029", {27'd0, ref_op(1'b1, 5'd8, 32'd10, 5'd8, 14'd25)}, {27'd0, 5'd8, 32'hFFFFFFF1});

        repeat (2) @(negedge clk);
        expect_out("reset", 5'd0, 32'd0);

        // Release reset with start already high: the first edge must capture.
        @(negedge clk);
        set_in(1'b0, 5'd10, 32'd100, 5'd10, 14'd50);
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_out("req027", 5'd10, 32'd150);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(i[0], 5'(i + 3), 32'hDEAD_0000 + 32'(i), 5'(i * 5), 14'(i * 777));
        end
        @(negedge clk);
        expect_out("hold", 5'd10, 32'd150);

        // Second start cycle lands in ALIGN and must be ignored.
        @(negedge clk);
        set_in(1'b0, 5'd10, 32'd5, 5'd12, 14'd3);
        start = 1'b1;
        @(negedge clk);
        set_in(1'b1, 5'd1, 32'd999, 5'd2, 14'd7);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        expect_out("req028", 5'd10, 32'd17);
        repeat (4) @(negedge clk);
        expect_out("no_queue", 5'd10, 32'd17);

        run_op(1'b1, 5'd8, 32'd10, 5'd8, 14'd25);
        expect_out("req029", 5'd8, 32'hFFFFFFF1);

        run_op(1'b0, 5'd0, 32'd0, 5'd31, 14'd1);
        expect_out("d31_in", 5'd0, 32'h80000000);
        run_op(1'b0, 5'd31, 32'd3, 5'd0, 14'd0);
        expect_out("d31_acc", 5'd0, 32'h80000000);
        run_op(1'b0, 5'd4, 32'h7FFFFFFF, 5'd4, 14'd1);
        expect_out("wrap", 5'd4, 32'h80000000);
        run_op(1'b1, 5'd2, 32'h80000000, 5'd2, 14'd1);
        expect_out("wrap_sub", 5'd2, 32'h7FFFFFFF);

        // Start held high: captures at cycles 0, 3, 6 only.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_in(1'b0, 5'd3, 32'(i * 100), 5'd3, 14'(i));
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("held_start", 5'd3, 32'd606);

        run_op(1'b0, 5'd16, 32'h1, 5'd15, 14'h21F6);
        expect_out("req026", 5'd15, 32'h21F8);

        // Abort during ALIGN with an asynchronous reset.
        @(negedge clk);
        set_in(1'b0, 5'd16, 32'h1, 5'd15, 14'h21F6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 rst = 1'b0;
        #1 expect_out("async_rst", 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        expect_out("post_abort", 5'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
